// File: rtl/drv_switch_entry_ctrl.sv
// Purpose: assembles a multi-digit BCD number from 10-key switch events, with commit, clear, timeout and overflow; option DRV_SWITCH_ENTRY_AUTOCOMMIT_EN commits when the buffer fills.
// Latency: key event -> o_digit 1 cycle; i_enter -> o_valid/o_bcd 1 cycle (autocommit: o_valid 1 cycle after the filling o_digit).
// Backpressure: none; inputs arriving during the one-cycle commit state are dropped.
module drv_switch_entry_ctrl #(
    parameter int p_digits  = 4,
    parameter int p_timeout = 50_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_val,
    input  logic                  i_unknown,
    input  logic                  i_toggle,
    input  logic                  i_enter,
    input  logic                  i_clear,
    output logic [4*p_digits-1:0] o_bcd,
    output logic [3:0]            o_count,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_digit,
    output logic                  o_overflow,
    output logic                  o_timeout
);
    localparam int W  = 4 * p_digits;
    localparam int TW = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (p_timeout > 0) ? TW'(p_timeout - 1) : '0;
    localparam logic [3:0]    FULL    = 4'(p_digits);
`ifdef DRV_SWITCH_ENTRY_AUTOCOMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT} state_t;

    state_t          state;
    logic [W-1:0]    buf_q;
    logic [3:0]      cnt_q;
    logic [TW-1:0]   idle_cnt;
    logic            commit_pend;
    logic            key_evt;
    logic [W-1:0]    buf_shift;

    // Releases and multi-key chords arrive with i_unknown set and never count as a key.
    assign key_evt   = i_toggle && !i_unknown && (i_val <= 4'd9);
    assign buf_shift = (buf_q << 4) | W'(i_val);
    assign o_busy    = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            idle_cnt    <= '0;
            commit_pend <= 1'b0;
            o_bcd       <= '0;
            o_count     <= '0;
            o_valid     <= 1'b0;
            o_digit     <= 1'b0;
            o_overflow  <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_valid    <= 1'b0;
            o_digit    <= 1'b0;
            o_overflow <= 1'b0;
            o_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_evt) begin
                        buf_q    <= W'(i_val);
                        cnt_q    <= 4'd1;
                        idle_cnt <= '0;
                        o_digit  <= 1'b1;
                        if (AUTO && FULL == 4'd1) begin
                            state       <= S_COMMIT;
                            commit_pend <= 1'b1;
                        end else begin
                            state <= S_ENTRY;
                        end
                    end
                end
                S_ENTRY: begin
                    if (i_clear) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        state <= S_IDLE;
                    end else if (i_enter) begin
                        // Outputs load here so o_valid lands one cycle after i_enter.
                        o_bcd       <= buf_q;
                        o_count     <= cnt_q;
                        o_valid     <= 1'b1;
                        commit_pend <= 1'b0;
                        state       <= S_COMMIT;
                    end else if (key_evt) begin
                        idle_cnt <= '0;
                        if (cnt_q < FULL) begin
                            buf_q   <= buf_shift;
                            cnt_q   <= cnt_q + 4'd1;
                            o_digit <= 1'b1;
                            if (AUTO && (cnt_q + 4'd1) == FULL) begin
                                state       <= S_COMMIT;
                                commit_pend <= 1'b1;
                            end
                        end else begin
                            o_overflow <= 1'b1;
                        end
                    end else if (p_timeout > 0 && idle_cnt == TO_LAST) begin
                        buf_q     <= '0;
                        cnt_q     <= '0;
                        o_timeout <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    // Autocommit arrives here without having loaded the outputs yet.
                    if (commit_pend) begin
                        o_bcd   <= buf_q;
                        o_count <= cnt_q;
                        o_valid <= 1'b1;
                    end
                    commit_pend <= 1'b0;
                    buf_q       <= '0;
                    cnt_q       <= '0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drv_switch_entry_ctrl.sv
// Bench for drv_switch_entry_ctrl: directed entry scenarios plus random key traffic against a digit-queue reference model.
module tb_drv_switch_entry_ctrl;
    localparam int D  = 4;
    localparam int TO = 100;
`ifdef DRV_SWITCH_ENTRY_AUTOCOMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [3:0]    i_val = '0;
    logic          i_unknown = 1'b1;
    logic          i_toggle = 1'b0;
    logic          i_enter = 1'b0;
    logic          i_clear = 1'b0;
    logic [4*D-1:0] o_bcd;
    logic [3:0]    o_count;
    logic          o_valid, o_busy, o_digit, o_overflow, o_timeout;

    drv_switch_entry_ctrl #(.p_digits(D), .p_timeout(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .i_unknown(i_unknown),
        .i_toggle(i_toggle), .i_enter(i_enter), .i_clear(i_clear),
        .o_bcd(o_bcd), .o_count(o_count), .o_valid(o_valid), .o_busy(o_busy),
        .o_digit(o_digit), .o_overflow(o_overflow), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the entry is a queue of typed digits plus a quiet-cycle count.
    int   digs[$];
    bit   m_entry, m_commit, m_auto_pend;
    int   m_quiet;
    int   m_bcd, m_count;
    bit   e_valid, e_digit, e_ovf, e_to;
    int   seen_to, seen_valid, seen_ovf;

    function automatic int pack_digits();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] v, input bit u, input bit t,
                              input bit e, input bit c);
        bit key;
        key = t && !u && (v <= 9);
        e_valid = 0; e_digit = 0; e_ovf = 0; e_to = 0;
        if (r) begin
            digs.delete(); m_entry = 0; m_commit = 0; m_auto_pend = 0;
            m_quiet = 0; m_bcd = 0; m_count = 0;
        end else if (m_commit) begin
            if (m_auto_pend) begin
                m_bcd = pack_digits(); m_count = digs.size(); e_valid = 1;
            end
            digs.delete(); m_commit = 0; m_auto_pend = 0; m_entry = 0;
        end else if (!m_entry) begin
            if (key) begin
                digs.delete(); digs.push_back(int'(v));
                e_digit = 1; m_entry = 1; m_quiet = 0;
            end
        end else if (c) begin
            digs.delete(); m_entry = 0;
        end else if (e) begin
            m_bcd = pack_digits(); m_count = digs.size(); e_valid = 1;
            m_commit = 1; m_auto_pend = 0;
        end else if (key) begin
            m_quiet = 0;
            if (digs.size() < D) begin
                digs.push_back(int'(v)); e_digit = 1;
                if (AUTO && digs.size() == D) begin
                    m_commit = 1; m_auto_pend = 1;
                end
            end else begin
                e_ovf = 1;
            end
        end else if (m_quiet + 1 >= TO) begin
            digs.delete(); m_entry = 0; e_to = 1;
        end else begin
            m_quiet++;
        end
    endtask

    task automatic cyc(input bit r, input logic [3:0] v, input bit u, input bit t,
                       input bit e, input bit c);
        i_rst = r; i_val = v; i_unknown = u; i_toggle = t; i_enter = e; i_clear = c;
        @(posedge i_clk);
        model_step(r, v, u, t, e, c);
        #1;
        seen_to    += int'(o_timeout);
        seen_valid += int'(o_valid);
        seen_ovf   += int'(o_overflow);
        check("valid",    32'(o_valid),    32'(e_valid));
        check("digit",    32'(o_digit),    32'(e_digit));
        check("overflow", 32'(o_overflow), 32'(e_ovf));
        check("timeout",  32'(o_timeout),  32'(e_to));
        check("busy",     32'(o_busy),     32'(m_entry || m_commit));
        check("bcd",      32'(o_bcd),      32'(m_bcd));
        check("count",    32'(o_count),    32'(m_count));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 4'd0, 1, 0, 0, 0);
    endtask

    // One press: encoded key toggle, release toggle (unknown), then a quiet cycle.
    task automatic key(input logic [3:0] v);
        cyc(0, v, 0, 1, 0, 0);
        cyc(0, 4'd0, 1, 1, 0, 0);
        cyc(0, 4'd0, 1, 0, 0, 0);
    endtask

    task automatic enter();
        cyc(0, 4'd0, 1, 0, 1, 0);
        idle(2);
    endtask

    initial begin
        seen_to = 0; seen_valid = 0; seen_ovf = 0;
        cyc(1, 4'd0, 1, 0, 0, 0);
        cyc(1, 4'd0, 1, 0, 0, 0);
        check("rst_bcd",  32'(o_bcd), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);

        key(4'd1); key(4'd2); key(4'd3);
        seen_valid = 0;
        enter();
        check("commit_0123", 32'(o_bcd), 32'h0123);
        check("commit_cnt3", 32'(o_count), 32'd3);
        check("commit_once", 32'(seen_valid), 32'd1);

        seen_ovf = 0;
        key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        if (AUTO) check("auto_9876", 32'(o_bcd), 32'h9876);
        key(4'd5);
        enter();
        if (AUTO) begin
            check("auto_new_entry", 32'(o_bcd), 32'h0005);
            check("auto_new_cnt",   32'(o_count), 32'd1);
            check("auto_no_ovf",    32'(seen_ovf), 32'd0);
        end else begin
            check("ovf_9876", 32'(o_bcd), 32'h9876);
            check("ovf_cnt4", 32'(o_count), 32'd4);
            check("ovf_seen", 32'(seen_ovf), 32'd1);
        end

        m_bcd = m_bcd;
        seen_valid = 0;
        key(4'd4);
        cyc(0, 4'd0, 1, 0, 1, 1);
        idle(2);
        check("clear_wins", 32'(seen_valid), 32'd0);
        check("clear_busy", 32'(o_busy), 32'd0);

        cyc(0, 4'd3, 1, 1, 0, 0);
        cyc(0, 4'hC, 0, 1, 0, 0);
        cyc(0, 4'hF, 0, 1, 0, 0);
        idle(1);
        check("ignored_idle", 32'(o_busy), 32'd0);

        seen_to = 0;
        key(4'd7);
        idle(105);
        check("timeout_once", 32'(seen_to), 32'd1);
        check("timeout_idle", 32'(o_busy), 32'd0);

        seen_to = 0;
        for (int k = 0; k < 4; k++) begin
            key(4'd2);
            idle(87);
        end
        check("no_timeout", 32'(seen_to), 32'd0);
        cyc(0, 4'd0, 1, 0, 0, 1);
        idle(1);

        key(4'd5); key(4'd5);
        cyc(1, 4'd0, 1, 0, 0, 0);
        check("rst_mid_bcd",  32'(o_bcd), 32'h0);
        check("rst_mid_cnt",  32'(o_count), 32'h0);
        check("rst_mid_busy", 32'(o_busy), 32'h0);
        seen_valid = 0;
        enter();
        check("rst_no_valid", 32'(seen_valid), 32'd0);

        for (int k = 0; k < 4000; k++) begin
            int p;
            p = $urandom_range(0, 999);
            if (p < 3) cyc(1, 4'd0, 1, 0, 0, 0);
            else if (p < 5) idle(110);
            else cyc(0, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
                     ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
